// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 64-bit ARMv8 register file with two combinational read ports and XZR.

module decoder5_32 (
  input  logic        enable,
  input  logic [4:0]  sel,
  output logic [31:0] lines
);

  always_comb begin
    lines = '0;
    if (enable) begin
      lines[sel] = 1'b1;
    end
  end

endmodule

module create_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] d,
  output logic [63:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

module giant_mux (
  input  logic [31:0][63:0] d,
  input  logic [4:0]        sel,
  output logic [63:0]       y
);

  // Two-level tree: four 8:1 groups, then a 4:1 pick on the high select bits.
  logic [3:0][63:0] group;

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      group[g] = d[g * 8 + int'(sel[2:0])];
    end
    y = group[sel[4:3]];
  end

endmodule

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  WriteRegister,
  input  logic [63:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2
);

  logic [31:0]       write_en;
  logic [31:0][63:0] bank;
  logic              unused_xzr_en;

  decoder5_32 u_decoder (
    .enable (RegWrite),
    .sel    (WriteRegister),
    .lines  (write_en)
  );

  genvar k;
  generate
    for (k = 0; k < 31; k++) begin : g_regs
      create_reg u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (write_en[k]),
        .d     (WriteData),
        .q     (bank[k])
      );
    end
  endgenerate

  // XZR has no storage; its decoded write strobe is deliberately dropped.
  assign bank[31]      = '0;
  assign unused_xzr_en = write_en[31];

  giant_mux u_mux1 (
    .d   (bank),
    .sel (ReadRegister1),
    .y   (ReadData1)
  );

  giant_mux u_mux2 (
    .d   (bank),
    .sel (ReadRegister2),
    .y   (ReadData2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against an array model.
`timescale 1ns/100ps

module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int total;
  int bad;
  bit started;

  logic [63:0] model [32];

  reg_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: an array that reset clears and a clocked write updates, XZR never stored.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      model[WriteRegister] = WriteData;
    end
  end

  function automatic logic [63:0] expect_read(input logic [4:0] idx);
    if (reset || idx == 5'd31) return 64'h0;
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_rd1", ReadData1, expect_read(ReadRegister1));
      chk("model_rd2", ReadData2, expect_read(ReadRegister2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] GATE_VAL = 64'h0000010204080001;

  initial begin
    total = 0;
    bad = 0;
    started = 0;
    reset = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // Reset pulse between clock edges.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    started = 1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #0.1;
      chk("reset_rd1", ReadData1, 64'h0);
      chk("reset_rd2", ReadData2, 64'h0);
    end

    // Fill: each index gets its own number.
    tick();
    for (int i = 0; i < 32; i++) begin
      WriteRegister = 5'(i);
      WriteData = 64'(i);
      RegWrite = 1'b0;
      tick();
      RegWrite = 1'b1;
      tick();
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(i + 1);
      #0.1;
      chk("fill_rd1", ReadData1, 64'(i));
      chk("fill_rd2", ReadData2, (i + 1 == 31) ? 64'h0 : 64'(i + 1));
    end

    // XZR ignores writes.
    tick();
    WriteRegister = 5'd31;
    WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd31;
    #0.1;
    chk("xzr", ReadData1, 64'h0);

    // Write gating.
    WriteRegister = 5'd3;
    WriteData = GATE_VAL;
    tick();
    tick();
    ReadRegister1 = 5'd3;
    #0.1;
    chk("gate_off", ReadData1, 64'd3);
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    #0.1;
    chk("gate_on_x3", ReadData1, GATE_VAL);
    chk("gate_on_x4", ReadData2, 64'd4);

    // Read-during-write: old value until the edge, new value right after.
    WriteRegister = 5'd5;
    WriteData = 64'd7;
    RegWrite = 1'b1;
    tick();
    WriteData = 64'd9;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    #0.1;
    chk("rdw_before1", ReadData1, 64'd7);
    chk("rdw_before2", ReadData2, 64'd7);
    tick();
    RegWrite = 1'b0;
    chk("rdw_after1", ReadData1, 64'd9);
    chk("rdw_after2", ReadData2, 64'd9);

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      RegWrite = 1'($urandom_range(0, 1));
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData = {32'($urandom), 32'($urandom)};
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      tick();
    end
    RegWrite = 1'b0;

    // Async reset mid-run, with a write attempt held across an edge while in reset.
    #2 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #0.1;
      chk("areset_rd1", ReadData1, 64'h0);
      chk("areset_rd2", ReadData2, 64'h0);
    end
    WriteRegister = 5'd2;
    WriteData = 64'hDEAD;
    RegWrite = 1'b1;
    tick();
    ReadRegister1 = 5'd2;
    #0.1;
    chk("reset_blocks_write", ReadData1, 64'h0);
    RegWrite = 1'b0;
    #1 reset = 1'b0;
    WriteRegister = 5'd1;
    WriteData = 64'd42;
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    ReadRegister1 = 5'd1;
    ReadRegister2 = 5'd1;
    #0.1;
    chk("post_reset_x1_rd1", ReadData1, 64'd42);
    chk("post_reset_x1_rd2", ReadData2, 64'd42);
    ReadRegister1 = 5'd2;
    #0.1;
    chk("post_reset_x2", ReadData1, 64'h0);

    tick();
    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
